ws2812_frame_sequencer: RTL and testbench

//  Upstream stage of the WS2812 bit serializer (LED_SWITCHING-class block).
//  - Holds one frame of N_LEDS 24-bit GRB pixels in a small write-port RAM.
//  - On i_start, streams the pixels in order 0..N_LEDS-1 to the serializer over a valid/ready handshake.
//  - Then requests the >50 us line-low latch gap before reporting done.

---
 rtl/ws2812_pkg.sv | 41 ++++
 rtl/ws2812_frame_sequencer_if.sv | 18 +
 rtl/ws2812_pixel_ram.sv | 50 +++++
 rtl/ws2812_frame_sequencer.sv | 136 +++++++++++++
 tb/tb_ws2812_frame_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/ws2812_pkg.sv
// ----------------------------------------------------------------------------
// ws2812_pkg
// Shared definitions for the WS2812 frame sequencer and its pixel RAM.
//  - state_t      : sequencer state encoding, also exported on o_state
//  - GRB_W        : pixel word width, with G/R/B field bounds
//  - CLK_HZ, LATCH_CYCLES_DEF : default timing (60 us latch gap at 100 MHz)
//  - grb_pack()   : builds a GRB word from separate colour bytes
// ----------------------------------------------------------------------------
package ws2812_pkg;

    localparam int GRB_W = 24;
    localparam int G_HI  = 23;
    localparam int G_LO  = 16;
    localparam int R_HI  = 15;
    localparam int R_LO  = 8;
    localparam int B_HI  = 7;
    localparam int B_LO  = 0;

    localparam int CLK_HZ           = 100_000_000;
    localparam int LATCH_CYCLES_DEF = 6000;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_PRESENT = 3'd2,
        ST_LATCH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    function automatic logic [GRB_W-1:0] grb_pack(input logic [7:0] g,
                                                  input logic [7:0] r,
                                                  input logic [7:0] b);
        logic [GRB_W-1:0] w;
        w              = '0;
        w[G_HI:G_LO]   = g;
        w[R_HI:R_LO]   = r;
        w[B_HI:B_LO]   = b;
        return w;
    endfunction

endpackage

// File: rtl/ws2812_frame_sequencer_if.sv
// ----------------------------------------------------------------------------
// ws2812_frame_sequencer_if
// Pixel stream between the frame sequencer and the bit serializer.
//  pix_valid : pix_grb holds a pixel (sequencer -> serializer)
//  pix_grb   : 24-bit pixel, [23:16] G, [15:8] R, [7:0] B
//  pix_ready : serializer accepts the pixel (serializer -> sequencer)
// Modports: master = sequencer side, slave = serializer side.
// ----------------------------------------------------------------------------
interface ws2812_frame_sequencer_if;
    import ws2812_pkg::*;

    logic             pix_valid;
    logic [GRB_W-1:0] pix_grb;
    logic             pix_ready;

    modport master (output pix_valid, output pix_grb, input  pix_ready);
    modport slave  (input  pix_valid, input  pix_grb, output pix_ready);
endinterface

// File: rtl/ws2812_pixel_ram.sv
// ----------------------------------------------------------------------------
// ws2812_pixel_ram
// N_LEDS x 24-bit frame store: one write port, one registered read port.
//  i_clk     : clock
//  i_wr_en   : write strobe; addresses >= N_LEDS are dropped
//  i_wr_addr : write pixel index
//  i_wr_grb  : write data
//  i_rd_en   : load the read register from i_rd_addr
//  i_rd_addr : read pixel index (always < N_LEDS)
//  o_rd_grb  : registered read data, held while i_rd_en is low
// Same-address read and write in one cycle returns the old word.
// Contents are not reset.
// ----------------------------------------------------------------------------
module ws2812_pixel_ram
    import ws2812_pkg::*;
#(
    parameter int N_LEDS = 8,
    parameter int AW     = 3
) (
    input  logic             i_clk,
    input  logic             i_wr_en,
    input  logic [AW-1:0]    i_wr_addr,
    input  logic [GRB_W-1:0] i_wr_grb,
    input  logic             i_rd_en,
    input  logic [AW-1:0]    i_rd_addr,
    output logic [GRB_W-1:0] o_rd_grb
);

    // One extra bit so the bound still compares correctly when N_LEDS == 2**AW.
    localparam logic [AW:0] DEPTH = (AW+1)'(N_LEDS);

    logic [GRB_W-1:0] r_mem [N_LEDS];
    logic [GRB_W-1:0] r_rd_grb;
    logic             w_wr_ok;

    assign w_wr_ok = i_wr_en && ({1'b0, i_wr_addr} < DEPTH);

    // Non-blocking read and write in the same process give read-first behaviour.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) begin
            r_mem[i_wr_addr] <= i_wr_grb;
        end
        if (i_rd_en) begin
            r_rd_grb <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_grb = r_rd_grb;

endmodule

// File: rtl/ws2812_frame_sequencer.sv
// ----------------------------------------------------------------------------
// ws2812_frame_sequencer
// Holds one frame of N_LEDS GRB pixels, streams them in order 0..N_LEDS-1 to
// the WS2812 serializer on start, then holds the line-low latch gap and
// pulses done.
//  i_clk      : clock (rising edge)
//  rst_n      : asynchronous active-low reset
//  i_wr_en    : pixel RAM write strobe (any state)
//  i_wr_addr  : pixel index to write
//  i_wr_grb   : pixel data, GRB
//  i_start    : frame start, honoured only in IDLE
//  pix        : pixel stream (master): pix_valid / pix_grb / pix_ready
//  o_latch    : high for the whole latch gap
//  o_busy     : high in every state but IDLE
//  o_done     : one-cycle pulse at end of frame
//  o_state    : current state encoding
// All outputs decode the async-reset state register, so they fall to zero
// the moment rst_n goes low.
// ----------------------------------------------------------------------------
module ws2812_frame_sequencer
    import ws2812_pkg::*;
#(
    parameter int N_LEDS       = 8,
    parameter int AW           = 3,
    parameter int LATCH_CYCLES = LATCH_CYCLES_DEF
) (
    input  logic                          i_clk,
    input  logic                          rst_n,
    input  logic                          i_wr_en,
    input  logic [AW-1:0]                 i_wr_addr,
    input  logic [GRB_W-1:0]              i_wr_grb,
    input  logic                          i_start,
    ws2812_frame_sequencer_if.master      pix,
    output logic                          o_latch,
    output logic                          o_busy,
    output logic                          o_done,
    output logic [2:0]                    o_state
);

    localparam int             CW       = $clog2(LATCH_CYCLES + 1);
    localparam logic [AW-1:0]  LAST_IDX = AW'(N_LEDS - 1);
    localparam logic [CW-1:0]  LAT_LAST = CW'(LATCH_CYCLES - 1);
    localparam logic [CW-1:0]  LAT_MAX  = CW'(LATCH_CYCLES);

    state_t           r_state, w_state_next;
    logic [AW-1:0]    r_index, w_index_next;
    logic [CW-1:0]    r_lcnt,  w_lcnt_next;
    logic             w_rd_en;
    logic [GRB_W-1:0] w_rd_grb;

    ws2812_pixel_ram #(
        .N_LEDS (N_LEDS),
        .AW     (AW)
    ) u_ram (
        .i_clk     (i_clk),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_grb  (i_wr_grb),
        .i_rd_en   (w_rd_en),
        .i_rd_addr (r_index),
        .o_rd_grb  (w_rd_grb)
    );

    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_index <= '0;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_next;
            r_index <= w_index_next;
            r_lcnt  <= w_lcnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_index_next  = r_index;
        w_lcnt_next   = r_lcnt;
        w_rd_en       = 1'b0;
        pix.pix_valid = 1'b0;
        pix.pix_grb   = '0;
        o_latch       = 1'b0;
        o_done        = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (i_start) begin
                    w_state_next = ST_LOAD;
                    w_index_next = '0;
                end
            end
            ST_LOAD: begin
                // Reading here (not earlier) lets late writes to this pixel land in the frame.
                w_rd_en      = 1'b1;
                w_state_next = ST_PRESENT;
            end
            ST_PRESENT: begin
                // Read register is only reloaded in LOAD, so the word stays put under backpressure.
                pix.pix_valid = 1'b1;
                pix.pix_grb   = w_rd_grb;
                if (pix.pix_ready) begin
                    if (r_index == LAST_IDX) begin
                        w_state_next = ST_LATCH;
                        w_lcnt_next  = '0;
                    end else begin
                        w_index_next = r_index + 1'b1;
                        w_state_next = ST_LOAD;
                    end
                end
            end
            ST_LATCH: begin
                o_latch = 1'b1;
                if (r_lcnt != LAT_MAX) begin
                    w_lcnt_next = r_lcnt + 1'b1;
                end
                // Counter value k marks the (k+1)-th latch cycle; leave after the last one.
                if (r_lcnt == LAT_LAST) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                o_done       = 1'b1;
                w_lcnt_next  = '0;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    assign o_busy  = (r_state != ST_IDLE);
    assign o_state = r_state;

endmodule

// File: tb/tb_ws2812_frame_sequencer.sv
// ----------------------------------------------------------------------------
// tb_ws2812_frame_sequencer
// Directed bench for ws2812_frame_sequencer: full frames, backpressure,
// ignored start requests, in-frame RAM writes, mid-frame reset and
// back-to-back frames. AW is widened to 4 so an out-of-range address (9)
// can be presented to the write port.
// ----------------------------------------------------------------------------
module tb_ws2812_frame_sequencer;
    import ws2812_pkg::*;

    localparam int N  = 8;
    localparam int AW = 4;
    localparam int LC = 6000;

    logic             i_clk     = 1'b0;
    logic             rst_n     = 1'b0;
    logic             i_wr_en   = 1'b0;
    logic [AW-1:0]    i_wr_addr = '0;
    logic [GRB_W-1:0] i_wr_grb  = '0;
    logic             i_start   = 1'b0;
    logic             o_latch;
    logic             o_busy;
    logic             o_done;
    logic [2:0]       o_state;

    ws2812_frame_sequencer_if pif();

    ws2812_frame_sequencer #(
        .N_LEDS       (N),
        .AW           (AW),
        .LATCH_CYCLES (LC)
    ) dut (
        .i_clk     (i_clk),
        .rst_n     (rst_n),
        .i_wr_en   (i_wr_en),
        .i_wr_addr (i_wr_addr),
        .i_wr_grb  (i_wr_grb),
        .i_start   (i_start),
        .pix       (pif),
        .o_latch   (o_latch),
        .o_busy    (o_busy),
        .o_done    (o_done),
        .o_state   (o_state)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;
    int overlap_cnt = 0;
    int done_cnt    = 0;
    logic [GRB_W-1:0] exp_pix [N];

    always @(negedge i_clk) begin
        if (pif.pix_valid && o_latch) overlap_cnt <= overlap_cnt + 1;
        if (o_done)                   done_cnt    <= done_cnt + 1;
    end

    task automatic step;
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr_pix(input logic [AW-1:0] a, input logic [GRB_W-1:0] d);
        i_wr_en   = 1'b1;
        i_wr_addr = a;
        i_wr_grb  = d;
        step;
        i_wr_en   = 1'b0;
    endtask

    // One frame from IDLE. Optional: stall on one pixel, stray start pulses,
    // and a write to pixel 6 plus address 9 while pixel 2 is on the bus.
    task automatic run_frame(input string tag, input int stall_pix, input int stall_len,
                             input bit inj_start, input bit inj_wr);
        int n;
        int lat;
        int sbad;
        int bbad;
        int lbad;
        pif.pix_ready = 1'b1;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        chk($sformatf("%s_load_state", tag), 32'(o_state), 32'd1);
        chk($sformatf("%s_load_novalid", tag), 32'(pif.pix_valid), 32'd0);
        step;
        chk($sformatf("%s_first_valid_t2", tag), 32'(pif.pix_valid), 32'd1);
        bbad = 0;
        for (int p = 0; p < N; p++) begin
            n = 0;
            while (!pif.pix_valid && n < 8) begin
                step;
                n++;
            end
            chk($sformatf("%s_valid_pix%0d", tag, p), 32'(pif.pix_valid), 32'd1);
            chk($sformatf("%s_grb_pix%0d", tag, p), 32'(pif.pix_grb), 32'(exp_pix[p]));
            if (p == stall_pix) begin
                pif.pix_ready = 1'b0;
                sbad = 0;
                repeat (stall_len) begin
                    step;
                    if (pif.pix_valid !== 1'b1 || pif.pix_grb !== exp_pix[p]) sbad++;
                end
                chk($sformatf("%s_stall_hold_pix%0d", tag, p), 32'(sbad), 32'd0);
                pif.pix_ready = 1'b1;
            end
            if (inj_wr && p == 2) begin
                i_wr_en   = 1'b1;
                i_wr_addr = 4'd6;
                i_wr_grb  = 24'hABCDEF;
            end
            if (inj_start && p == 1) i_start = 1'b1;
            step;
            i_start = 1'b0;
            if (p < N - 1 && pif.pix_valid !== 1'b0) bbad++;
            if (inj_wr && p == 2) begin
                i_wr_addr = 4'd9;
                i_wr_grb  = 24'h111111;
                step;
                i_wr_en   = 1'b0;
            end
        end
        chk($sformatf("%s_bubbles", tag), 32'(bbad), 32'd0);
        chk($sformatf("%s_latch_rise", tag), 32'(o_latch), 32'd1);
        lat  = 0;
        lbad = 0;
        while (o_latch && lat < LC + 100) begin
            if (pif.pix_valid) lbad++;
            i_start = (inj_start && lat == 100);
            lat++;
            step;
        end
        i_start = 1'b0;
        chk($sformatf("%s_latch_len", tag), 32'(lat), 32'(LC));
        chk($sformatf("%s_latch_novalid", tag), 32'(lbad), 32'd0);
        chk($sformatf("%s_done_pulse", tag), 32'(o_done), 32'd1);
        chk($sformatf("%s_done_state", tag), 32'(o_state), 32'd4);
        if (inj_start) i_start = 1'b1;
        step;
        i_start = 1'b0;
        chk($sformatf("%s_done_cleared", tag), 32'(o_done), 32'd0);
        chk($sformatf("%s_back_idle", tag), 32'(o_state), 32'd0);
        chk($sformatf("%s_not_busy", tag), 32'(o_busy), 32'd0);
        if (inj_start) begin
            sbad = 0;
            repeat (5) begin
                step;
                if (o_state !== 3'd0 || o_busy !== 1'b0) sbad++;
            end
            chk($sformatf("%s_no_second_frame", tag), 32'(sbad), 32'd0);
        end
        $display("frame %s complete: latch cycles=%0d", tag, lat);
    endtask

    initial begin
        int cnt;
        int n;
        pif.pix_ready = 1'b0;

        exp_pix[0] = 24'h0000FF;
        exp_pix[1] = 24'h00FF00;
        exp_pix[2] = 24'hFF0000;
        exp_pix[3] = 24'hFFFFFF;
        exp_pix[4] = 24'h123456;
        exp_pix[5] = 24'h654321;
        exp_pix[6] = 24'h0F0F0F;
        exp_pix[7] = grb_pack(8'hF0, 8'h0F, 8'h5A);

        // Reset state
        repeat (3) step;
        chk("rst_state", 32'(o_state), 32'd0);
        chk("rst_valid", 32'(pif.pix_valid), 32'd0);
        chk("rst_grb", 32'(pif.pix_grb), 32'd0);
        chk("rst_latch", 32'(o_latch), 32'd0);
        chk("rst_busy", 32'(o_busy), 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        rst_n = 1'b1;
        step;

        for (int i = 0; i < N; i++) wr_pix(AW'(i), exp_pix[i]);
        chk("idle_after_writes", 32'(o_busy), 32'd0);

        // 1: plain frame
        run_frame("f1", -1, 0, 1'b0, 1'b0);
        // 2+3: backpressure on pixel 3 and stray starts in PRESENT/LATCH/DONE
        run_frame("f2", 3, 50, 1'b1, 1'b0);
        // 4: in-frame write to pixel 6, out-of-range write to 9
        exp_pix[6] = 24'hABCDEF;
        run_frame("f3", -1, 0, 1'b0, 1'b1);

        // 5: reset while pixel 4 is presented
        pif.pix_ready = 1'b1;
        i_start = 1'b1;
        step;
        i_start = 1'b0;
        cnt = 0;
        n   = 0;
        while (n < 100) begin
            if (pif.pix_valid && cnt == 4) break;
            if (pif.pix_valid) cnt++;
            step;
            n++;
        end
        chk("r5_reached_pix4", 32'(cnt), 32'd4);
        chk("r5_pix4_grb", 32'(pif.pix_grb), 32'(exp_pix[4]));
        #2;
        rst_n = 1'b0;
        #1;
        chk("r5_async_state", 32'(o_state), 32'd0);
        chk("r5_async_valid", 32'(pif.pix_valid), 32'd0);
        chk("r5_async_grb", 32'(pif.pix_grb), 32'd0);
        chk("r5_async_busy", 32'(o_busy), 32'd0);
        chk("r5_async_latch", 32'(o_latch), 32'd0);
        chk("r5_async_done", 32'(o_done), 32'd0);
        step;
        step;
        rst_n = 1'b1;
        step;
        chk("r5_idle_after_release", 32'(o_state), 32'd0);
        run_frame("f4", -1, 0, 1'b0, 1'b0);

        // 6: back-to-back frames, start in the cycle after done
        run_frame("f5", -1, 0, 1'b0, 1'b0);
        run_frame("f6", -1, 0, 1'b0, 1'b0);

        step;
        chk("done_pulse_count", 32'(done_cnt), 32'd6);
        chk("latch_valid_overlap", 32'(overlap_cnt), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
